benes_loop_setter: RTL and testbench



---
 rtl/benes_loop_setter.sv | 211 +++++++++++++++++++++
 tb/tb_benes_loop_setter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_loop_setter.sv
// Looping-algorithm engine that sets the outer switches of an N-port Benes net.
// Define PERM_CHECK_EN to add a duplicate-entry check and the perm_err port.
module benes_loop_setter #(
    parameter  int LOGN = 3,
    localparam int N    = 2 ** LOGN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N*LOGN-1:0]   perm_in,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic [N/2-1:0]      in_sw,
    output logic [N/2-1:0]      out_sw
`ifdef PERM_CHECK_EN
    ,
    output logic                perm_err
`endif
);

    localparam int H = N / 2;

    typedef logic [LOGN-1:0] idx_t;
    typedef logic [LOGN-2:0] sw_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEEK,
        WALK,
        DONE
    } state_t;

    state_t         state_q, state_d;
    idx_t           p_q [N];
    idx_t           q_q [N];
    idx_t           k_q, k_d;
    logic [H-1:0]   visited_q, visited_d;
    logic [N-1:0]   colour_q, colour_d;
    logic [H-1:0]   in_sw_q, in_sw_d;
    logic [H-1:0]   out_sw_q, out_sw_d;

    idx_t           k_x;
    idx_t           nxt;
    logic [H-1:0]   vis_walk;
    logic [N-1:0]   col_walk;
    logic           walk_hit;
    logic           all_vis;
    sw_t            seek_s;
    logic           dup;

    // One WALK step: colour the current switch, then follow the chain.
    always_comb begin
        k_x      = k_q ^ idx_t'(1);
        nxt      = q_q[p_q[k_x] ^ idx_t'(1)];
        vis_walk = visited_q;
        vis_walk[k_q[LOGN-1:1]] = 1'b1;
        col_walk = colour_q;
        col_walk[k_q] = 1'b0;
        col_walk[k_x] = 1'b1;
        walk_hit = vis_walk[nxt[LOGN-1:1]];
        all_vis  = &vis_walk;
    end

    always_comb begin
        seek_s = '0;
        for (int s = H - 1; s >= 0; s--) begin
            if (!visited_q[s]) seek_s = sw_t'(s);
        end
    end

`ifdef PERM_CHECK_EN
    logic [N-1:0] hit;
    logic         perm_err_q;

    always_comb begin
        hit = '0;
        dup = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (hit[p_q[i]]) dup = 1'b1;
            hit[p_q[i]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_err_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            perm_err_q <= 1'b0;
        end else if (state_q == LOAD) begin
            perm_err_q <= dup;
        end
    end

    assign perm_err = perm_err_q;
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                state_d = dup ? DONE : SEEK;
            end
            SEEK: begin
                state_d = WALK;
            end
            WALK: begin
                if (walk_hit) state_d = all_vis ? DONE : SEEK;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            IDLE:             ready = 1'b1;
            LOAD, SEEK, WALK: busy  = 1'b1;
            DONE:             done  = 1'b1;
            default:          ;
        endcase
    end

    // Switch settings are latched on entry to DONE so they are valid with done.
    always_comb begin
        k_d       = k_q;
        visited_d = visited_q;
        colour_d  = colour_q;
        in_sw_d   = in_sw_q;
        out_sw_d  = out_sw_q;
        unique case (state_q)
            LOAD: begin
                visited_d = '0;
                colour_d  = '0;
                in_sw_d   = '0;
                out_sw_d  = '0;
            end
            SEEK: begin
                k_d = {seek_s, 1'b0};
            end
            WALK: begin
                visited_d = vis_walk;
                colour_d  = col_walk;
                if (!walk_hit) begin
                    k_d = nxt;
                end else if (all_vis) begin
                    for (int s = 0; s < H; s++) begin
                        in_sw_d[s]  = col_walk[2*s];
                        out_sw_d[s] = col_walk[q_q[2*s]];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                p_q[i] <= '0;
                q_q[i] <= '0;
            end
            k_q       <= '0;
            visited_q <= '0;
            colour_q  <= '0;
            in_sw_q   <= '0;
            out_sw_q  <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                for (int i = 0; i < N; i++) begin
                    p_q[i] <= perm_in[i*LOGN +: LOGN];
                end
            end
            if (state_q == LOAD) begin
                for (int i = 0; i < N; i++) begin
                    q_q[p_q[i]] <= idx_t'(i);
                end
            end
            k_q       <= k_d;
            visited_q <= visited_d;
            colour_q  <= colour_d;
            in_sw_q   <= in_sw_d;
            out_sw_q  <= out_sw_d;
        end
    end

    assign in_sw  = in_sw_q;
    assign out_sw = out_sw_q;

endmodule

// File: tb/tb_benes_loop_setter.sv
// Bench for benes_loop_setter: directed jobs, per-cycle compare against a
// looping-algorithm model, plus hand-computed switch settings and latencies.
`timescale 1ns/1ps
module tb_benes_loop_setter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [23:0] perm_in = '0;
    logic        ready, busy, done;
    logic [3:0]  in_sw, out_sw;

    logic        start2 = 1'b0;
    logic [7:0]  perm2 = '0;
    logic        ready2, busy2, done2;
    logic [1:0]  in2, out2;

`ifdef PERM_CHECK_EN
    logic        perm_err, perm_err2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    benes_loop_setter #(.LOGN(3)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .perm_in (perm_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .in_sw   (in_sw),
        .out_sw  (out_sw)
`ifdef PERM_CHECK_EN
        ,
        .perm_err(perm_err)
`endif
    );

    benes_loop_setter #(.LOGN(2)) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start2),
        .perm_in (perm2),
        .ready   (ready2),
        .busy    (busy2),
        .done    (done2),
        .in_sw   (in2),
        .out_sw  (out2)
`ifdef PERM_CHECK_EN
        ,
        .perm_err(perm_err2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5,
                                       input int a6, input int a7);
        logic [23:0] v;
        v = {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
        return v;
    endfunction

    typedef struct packed {
        logic [3:0] isw;
        logic [3:0] osw;
        logic [7:0] lat;
        logic       err;
    } res_t;

    // Looping algorithm on arrays: colour each chain, count loops.
    function automatic res_t model(input logic [23:0] pv);
        res_t r;
        int   p[8];
        int   q[8];
        bit   col[8];
        bit   vis[4];
        int   loops;
        int   k;
        r = '0;
        loops = 0;
        for (int i = 0; i < 8; i++) begin
            p[i] = int'(pv[i*3 +: 3]);
            q[i] = 0;
            col[i] = 1'b0;
        end
        for (int s = 0; s < 4; s++) vis[s] = 1'b0;
        for (int i = 0; i < 8; i++) q[p[i]] = i;
`ifdef PERM_CHECK_EN
        begin
            bit seen[8];
            for (int i = 0; i < 8; i++) seen[i] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (seen[p[i]]) r.err = 1'b1;
                seen[p[i]] = 1'b1;
            end
        end
        if (r.err) begin
            r.lat = 8'd2;
            return r;
        end
`endif
        for (int s = 0; s < 4; s++) begin
            if (!vis[s]) begin
                loops++;
                k = 2 * s;
                while (!vis[k/2]) begin
                    vis[k/2] = 1'b1;
                    col[k] = 1'b0;
                    col[k^1] = 1'b1;
                    k = q[p[k^1] ^ 1];
                end
            end
        end
        r.lat = 8'(2 + loops + 4);
        for (int s = 0; s < 4; s++) begin
            r.isw[s] = col[2*s];
            r.osw[s] = col[q[2*s]];
        end
        return r;
    endfunction

    // Expected timeline: cycles since the accepted start.
    int         t_cnt = 0;
    res_t       t_res = '0;
    logic [3:0] t_in = '0;
    logic [3:0] t_out = '0;
    logic       t_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_cnt <= 0;
            t_res <= '0;
            t_in  <= '0;
            t_out <= '0;
            t_err <= 1'b0;
        end else if (t_cnt == 0) begin
            if (start) begin
                t_cnt <= 1;
                t_res <= model(perm_in);
                t_err <= 1'b0;
            end
        end else begin
            t_cnt <= (t_cnt == int'(t_res.lat)) ? 0 : t_cnt + 1;
            if (t_cnt == 1) begin
                t_in  <= '0;
                t_out <= '0;
                t_err <= t_res.err;
            end
            if (t_cnt + 1 == int'(t_res.lat)) begin
                t_in  <= t_res.isw;
                t_out <= t_res.osw;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", {31'b0, ready}, {31'b0, t_cnt == 0});
        chk("busy", {31'b0, busy}, {31'b0, t_cnt != 0 && t_cnt != int'(t_res.lat)});
        chk("done", {31'b0, done}, {31'b0, t_cnt != 0 && t_cnt == int'(t_res.lat)});
        chk("in_sw", {28'b0, in_sw}, {28'b0, t_in});
        chk("out_sw", {28'b0, out_sw}, {28'b0, t_out});
`ifdef PERM_CHECK_EN
        chk("perm_err", {31'b0, perm_err}, {31'b0, t_err});
`endif
    end

    task automatic kick(input logic [23:0] pv);
        @(negedge clk);
        perm_in = pv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_job(input string nm, input int n0, input logic [3:0] ei,
                              input logic [3:0] eo, input int el);
        int n;
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, n, el);
        chk({nm, "_in"}, {28'b0, in_sw}, {28'b0, ei});
        chk({nm, "_out"}, {28'b0, out_sw}, {28'b0, eo});
    endtask

    task automatic run_job(input string nm, input logic [23:0] pv,
                           input logic [3:0] ei, input logic [3:0] eo, input int el);
        kick(pv);
        finish_job(nm, 1, ei, eo, el);
    endtask

    logic [23:0] p_id, p_swap, p_one, p_rot, p_odd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        p_id   = pk(0, 1, 2, 3, 4, 5, 6, 7);
        p_swap = pk(1, 0, 3, 2, 5, 4, 7, 6);
        p_one  = pk(0, 2, 1, 3, 4, 5, 6, 7);
        p_rot  = pk(1, 2, 3, 4, 5, 6, 7, 0);
        p_odd  = pk(3, 6, 0, 5, 1, 7, 2, 4);

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        #2 rst_n = 1'b1;

        run_job("identity", p_id, 4'b0000, 4'b0000, 10);
        @(negedge clk);
        chk("ready_after_done", {31'b0, ready}, 32'd1);
        run_job("swap", p_swap, 4'b0000, 4'b1111, 10);
        run_job("split", p_one, 4'b0010, 4'b0010, 9);
        run_job("rotate", p_rot, 4'b0000, 4'b1111, 7);

        // back-to-back: start again in the cycle ready returns
        @(negedge clk);
        perm_in = p_odd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("held_out", {28'b0, out_sw}, 32'hf);
        @(negedge clk);
        chk("cleared_out", {28'b0, out_sw}, 32'h0);
        finish_job("b2b_odd", 2, 4'b1100, 4'b1010, 7);

        // reset while idle with non-zero outputs
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("idle_rst_in", {28'b0, in_sw}, 32'h0);
        chk("idle_rst_out", {28'b0, out_sw}, 32'h0);
        #2 rst_n = 1'b1;

        // extra start during WALK is ignored
        kick(p_odd);
        repeat (2) @(negedge clk);
        perm_in = p_id;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_job("ignore_start", 4, 4'b1100, 4'b1010, 7);

        // reset mid-WALK, then a fresh job
        kick(p_rot);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run_job("after_rst", p_odd, 4'b1100, 4'b1010, 7);
        run_job("after_rst2", p_swap, 4'b0000, 4'b1111, 10);

        // LOGN=2 single loop
        @(negedge clk);
        perm2 = 8'b11_01_10_00;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("n4_lat", n, 5);
        chk("n4_in", {30'b0, in2}, 32'b10);
        chk("n4_out", {30'b0, out2}, 32'b10);
        @(negedge clk);
        chk("n4_ready", {31'b0, ready2}, 32'd1);

`ifdef PERM_CHECK_EN
        kick(pk(0, 0, 2, 3, 4, 5, 6, 7));
        n = 1;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("dup_lat_bound", {31'b0, n <= 3}, 32'd1);
        chk("dup_err", {31'b0, perm_err}, 32'd1);
        chk("dup_in", {28'b0, in_sw}, 32'h0);
        chk("dup_out", {28'b0, out_sw}, 32'h0);
        run_job("after_dup", p_odd, 4'b1100, 4'b1010, 7);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
